// File: rtl/md_pkg.sv
// Shared definitions for the HI/LO multiply/divide sequencer.
// Op encoding, FSM states and counter width.
package md_pkg;

  localparam int MD_CNT_W = 4;

  localparam logic [2:0] MD_MULT  = 3'd0;
  localparam logic [2:0] MD_MULTU = 3'd1;
  localparam logic [2:0] MD_DIV   = 3'd2;
  localparam logic [2:0] MD_DIVU  = 3'd3;
  localparam logic [2:0] MD_MTHI  = 3'd4;
  localparam logic [2:0] MD_MTLO  = 3'd5;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } md_state_e;

endpackage

// File: rtl/md_alu.sv
// Combinational multiply/divide datapath for the latched operands.
// Signed and unsigned forms share one multiplier and one divider.
module md_alu
  import md_pkg::*;
(
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic [2:0]  op,
  output logic [31:0] res_hi,
  output logic [31:0] res_lo,
  output logic        div_by_zero
);

  logic        sgn_mul;
  logic        sgn_div;
  logic [63:0] ma;
  logic [63:0] mb;
  logic [63:0] prod;
  logic [31:0] abs_a;
  logic [31:0] abs_b;
  logic [31:0] dvd;
  logic [31:0] dvs;
  logic [31:0] qm;
  logic [31:0] rm;
  logic [31:0] q_s;
  logic [31:0] r_s;

  assign sgn_mul = (op == MD_MULT);
  assign sgn_div = (op == MD_DIV);

  assign ma   = {{32{sgn_mul & a[31]}}, a};
  assign mb   = {{32{sgn_mul & b[31]}}, b};
  assign prod = ma * mb;

  assign abs_a = a[31] ? (~a + 32'd1) : a;
  assign abs_b = b[31] ? (~b + 32'd1) : b;

  // Zero divisor is replaced by 1 so the divider never sees it.
  assign dvd = sgn_div ? abs_a : a;
  assign dvs = (b == 32'd0) ? 32'd1
             : (sgn_div ? abs_b : b);

  assign qm = dvd / dvs;
  assign rm = dvd % dvs;

  assign q_s = (a[31] ^ b[31]) ? (~qm + 32'd1) : qm;
  assign r_s = a[31] ? (~rm + 32'd1) : rm;

  assign div_by_zero = (op == MD_DIV || op == MD_DIVU)
                     && (b == 32'd0);

  always_comb begin
    res_hi = 32'd0;
    res_lo = 32'd0;
    unique case (1'b1)
      (op == MD_MULT),
      (op == MD_MULTU): begin
        res_hi = prod[63:32];
        res_lo = prod[31:0];
      end
      (op == MD_DIV): begin
        res_hi = r_s;
        res_lo = q_s;
      end
      (op == MD_DIVU): begin
        res_hi = rm;
        res_lo = qm;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/md_ctrl.sv
// HI/LO owner: latency-counting FSM, HI/LO registers and
// the ID-stage stall request.
module md_ctrl
  import md_pkg::*;
#(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [2:0]  op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic        cancel,
  input  logic        id_uses_md,
  output logic        busy,
  output logic        stall,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  localparam logic [MD_CNT_W-1:0] MULT_CNT =
    MD_CNT_W'(MULT_CYCLES);
  localparam logic [MD_CNT_W-1:0] DIV_CNT =
    MD_CNT_W'(DIV_CYCLES);
  localparam logic [MD_CNT_W-1:0] CNT_ONE =
    MD_CNT_W'(1);

  md_state_e             state_q, state_d;
  logic [MD_CNT_W-1:0]   count_q, count_d;
  logic [31:0]           a_q, a_d;
  logic [31:0]           b_q, b_d;
  logic [2:0]            op_q, op_d;
  logic [31:0]           hi_q, hi_d;
  logic [31:0]           lo_q, lo_d;

  logic [31:0] res_hi;
  logic [31:0] res_lo;
  logic        div_by_zero;
  logic        is_arith;
  logic        is_div;

  md_alu u_alu (
    .a           (a_q),
    .b           (b_q),
    .op          (op_q),
    .res_hi      (res_hi),
    .res_lo      (res_lo),
    .div_by_zero (div_by_zero)
  );

  assign is_arith = ~op[2];
  assign is_div   = (op == MD_DIV) || (op == MD_DIVU);

  always_comb begin
    state_d = state_q;
    count_d = count_q;
    a_d     = a_q;
    b_d     = b_q;
    op_d    = op_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    unique case (state_q)
      ST_IDLE: begin
        if (start && !cancel) begin
          unique case (1'b1)
            is_arith: begin
              a_d     = a;
              b_d     = b;
              op_d    = op;
              count_d = is_div ? DIV_CNT : MULT_CNT;
              state_d = ST_RUN;
            end
            (op == MD_MTHI): hi_d = a;
            (op == MD_MTLO): lo_d = a;
            default: ;
          endcase
        end
      end
      ST_RUN: begin
        if (cancel) begin
          state_d = ST_IDLE;
          count_d = '0;
        end else if (count_q == CNT_ONE) begin
          state_d = ST_IDLE;
          count_d = '0;
          if (!div_by_zero) begin
            hi_d = res_hi;
            lo_d = res_lo;
          end
        end else begin
          count_d = count_q - CNT_ONE;
        end
      end
      default: begin
        state_d = ST_IDLE;
        count_d = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= ST_IDLE;
      count_q <= '0;
      a_q     <= '0;
      b_q     <= '0;
      op_q    <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      a_q     <= a_d;
      b_q     <= b_d;
      op_q    <= op_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
    end
  end

  assign busy  = (state_q == ST_RUN);
  // Also covers an ID-stage HI/LO user in the issue cycle.
  assign stall = id_uses_md
               & (busy | (start & is_arith & ~cancel));
  assign hi    = hi_q;
  assign lo    = lo_q;

endmodule

// File: tb/tb_md_ctrl.sv
// Self-checking bench for md_ctrl against an arithmetic
// reference model of HI/LO.
module tb_md_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [2:0]  op;
  logic [31:0] a;
  logic [31:0] b;
  logic        cancel;
  logic        id_uses_md;
  logic        busy;
  logic        stall;
  logic [31:0] hi;
  logic [31:0] lo;

  int checks = 0;
  int errors = 0;

  logic [31:0] m_hi = 32'd0;
  logic [31:0] m_lo = 32'd0;

  md_ctrl #(
    .MULT_CYCLES (5),
    .DIV_CYCLES  (10)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .op         (op),
    .a          (a),
    .b          (b),
    .cancel     (cancel),
    .id_uses_md (id_uses_md),
    .busy       (busy),
    .stall      (stall),
    .hi         (hi),
    .lo         (lo)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Architectural effect of a completed op on HI/LO.
  function automatic void ref_op(input logic [2:0] o,
                                 input logic [31:0] x,
                                 input logic [31:0] y);
    longint sx, sy, q, r;
    longint unsigned ux, uy, p;
    sx = longint'($signed(x));
    sy = longint'($signed(y));
    ux = longint'(x);
    uy = longint'(y);
    case (o)
      3'd0: begin
        p = longint'(sx * sy);
        m_hi = p[63:32];
        m_lo = p[31:0];
      end
      3'd1: begin
        p = ux * uy;
        m_hi = p[63:32];
        m_lo = p[31:0];
      end
      3'd2: if (y != 0) begin
        q = sx / sy;
        r = sx - q * sy;
        m_lo = q[31:0];
        m_hi = r[31:0];
      end
      3'd3: if (y != 0) begin
        m_lo = 32'(ux / uy);
        m_hi = 32'(ux % uy);
      end
      default: ;
    endcase
  endfunction

  task automatic run_md(input logic [2:0] o,
                        input logic [31:0] x,
                        input logic [31:0] y,
                        input int cancel_at,
                        input bit inject,
                        input bit use_id);
    int n, cnt, exp_n;
    bit done;
    n = (o < 3'd2) ? 5 : 10;
    @(posedge clk); #1;
    start = 1'b1; op = o; a = x; b = y;
    id_uses_md = use_id;
    #1;
    if (use_id) chk("stall_issue", {31'd0, stall}, 32'd1);
    @(posedge clk); #1;
    start = 1'b0;
    cnt = 0;
    done = 1'b0;
    for (int i = 0; i < 40 && !done; i++) begin
      @(negedge clk);
      start = 1'b0;
      cancel = 1'b0;
      #1;
      if (busy) begin
        cnt++;
        if (use_id)
          chk("stall_busy", {31'd0, stall}, 32'd1);
        if (cnt == cancel_at) begin
          cancel = 1'b1;
        end else if (inject) begin
          start = 1'b1;
          op = 3'($urandom_range(0, 7));
          a = $urandom;
          b = $urandom;
        end
      end else begin
        done = 1'b1;
      end
    end
    chk("busy_done", {31'd0, done}, 32'd1);
    exp_n = (cancel_at != 0) ? cancel_at : n;
    chk("busy_cycles", cnt, exp_n);
    if (cancel_at == 0) ref_op(o, x, y);
    if (use_id) chk("stall_fall", {31'd0, stall}, 32'd0);
    chk("hi", hi, m_hi);
    chk("lo", lo, m_lo);
    id_uses_md = 1'b0;
  endtask

  task automatic mt(input logic [2:0] o,
                    input logic [31:0] x);
    @(posedge clk); #1;
    start = 1'b1; op = o; a = x;
    @(posedge clk); #1;
    start = 1'b0;
    if (o == 3'd4) m_hi = x;
    if (o == 3'd5) m_lo = x;
    @(negedge clk);
    chk("mt_busy", {31'd0, busy}, 32'd0);
    chk("mt_hi", hi, m_hi);
    chk("mt_lo", lo, m_lo);
  endtask

  task automatic start_cancel(input logic [2:0] o,
                              input logic [31:0] x);
    @(posedge clk); #1;
    start = 1'b1; op = o; a = x; b = 32'd3;
    cancel = 1'b1; id_uses_md = 1'b1;
    #1;
    chk("sc_stall", {31'd0, stall}, 32'd0);
    @(posedge clk); #1;
    start = 1'b0; cancel = 1'b0; id_uses_md = 1'b0;
    @(negedge clk);
    chk("sc_busy", {31'd0, busy}, 32'd0);
    chk("sc_hi", hi, m_hi);
    chk("sc_lo", lo, m_lo);
  endtask

  initial begin
    logic [2:0]  ro;
    logic [31:0] rx, ry;
    int          rc;
    reset = 1'b0; start = 1'b0; op = 3'd0;
    a = 32'd0; b = 32'd0;
    cancel = 1'b0; id_uses_md = 1'b0;
    #1;
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_stall", {31'd0, stall}, 32'd0);
    chk("rst_hi", hi, 32'd0);
    chk("rst_lo", lo, 32'd0);
    repeat (2) @(negedge clk);
    reset = 1'b1;

    run_md(3'd0, 32'hFFFF_FFFE, 32'd3, 0, 1'b0, 1'b0);
    chk("mult_hi", hi, 32'hFFFF_FFFF);
    chk("mult_lo", lo, 32'hFFFF_FFFA);
    run_md(3'd1, 32'hFFFF_FFFE, 32'd3, 0, 1'b0, 1'b0);
    chk("multu_hi", hi, 32'h0000_0002);
    chk("multu_lo", lo, 32'hFFFF_FFFA);
    run_md(3'd2, 32'hFFFF_FFF9, 32'd2, 0, 1'b0, 1'b0);
    chk("div_hi", hi, 32'hFFFF_FFFF);
    chk("div_lo", lo, 32'hFFFF_FFFD);
    run_md(3'd2, 32'h8000_0000, 32'hFFFF_FFFF,
           0, 1'b0, 1'b0);
    chk("ovf_hi", hi, 32'd0);
    chk("ovf_lo", lo, 32'h8000_0000);

    mt(3'd4, 32'h11);
    mt(3'd5, 32'h22);
    run_md(3'd3, 32'd5, 32'd0, 0, 1'b0, 1'b0);
    chk("dz_hi", hi, 32'h11);
    chk("dz_lo", lo, 32'h22);

    run_md(3'd0, 32'h1234_5678, 32'h9ABC_DEF0,
           0, 1'b1, 1'b1);
    mt(3'd5, 32'h1234);
    chk("mtlo_val", lo, 32'h1234);

    run_md(3'd2, 32'd100, 32'd7, 4, 1'b0, 1'b0);
    run_md(3'd0, 32'd9, 32'd9, 5, 1'b0, 1'b1);
    start_cancel(3'd0, 32'h55);
    start_cancel(3'd4, 32'hDEAD);
    start_cancel(3'd5, 32'hBEEF);
    mt(3'd6, 32'hCAFE);

    // Asynchronous reset in the middle of a divide.
    @(posedge clk); #1;
    start = 1'b1; op = 3'd2; a = 32'd77; b = 32'd5;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (3) @(negedge clk);
    #2;
    reset = 1'b0;
    #1;
    chk("mid_rst_busy", {31'd0, busy}, 32'd0);
    chk("mid_rst_hi", hi, 32'd0);
    chk("mid_rst_lo", lo, 32'd0);
    m_hi = 32'd0;
    m_lo = 32'd0;
    @(negedge clk);
    reset = 1'b1;
    run_md(3'd1, 32'd6, 32'd7, 0, 1'b0, 1'b0);

    for (int i = 0; i < 30; i++) begin
      ro = 3'($urandom_range(0, 5));
      rx = $urandom;
      ry = ($urandom_range(0, 5) == 0) ? 32'd0 : $urandom;
      if ($urandom_range(0, 7) == 0) begin
        rx = 32'h8000_0000;
        ry = 32'hFFFF_FFFF;
      end
      if (ro >= 3'd4) begin
        mt(ro, rx);
      end else begin
        rc = 0;
        if ($urandom_range(0, 4) == 0)
          rc = $urandom_range(1, (ro < 3'd2) ? 5 : 10);
        run_md(ro, rx, ry, rc,
               1'($urandom_range(0, 1)),
               1'($urandom_range(0, 1)));
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/md_ctrl.md
Name: md_ctrl

Overview:
- Multi-cycle multiply/divide sequencer for the MIPS datapath.
- Owns the HI/LO registers and accepts MULT/MULTU/DIV/DIVU/MTHI/MTLO issued from the EX stage.
- Models the fixed operation latency with a busy counter.
- Raises a stall request to the hazard logic when the instruction in ID needs HI/LO while an operation is in flight.

Parameters:
- MULT_CYCLES, 5, busy cycles for MULT/MULTU (legal range 1..15)
- DIV_CYCLES, 10, busy cycles for DIV/DIVU (legal range 1..15)

Ports:
- clk  in  1  system clock, rising edge
- reset  in  1  asynchronous, active-low reset (0 = reset asserted)
- start  in  1  EX-stage HI/LO instruction valid, one-cycle pulse
- op  in  3  operation: 0 MULT, 1 MULTU, 2 DIV, 3 DIVU, 4 MTHI, 5 MTLO; 6-7 reserved
- a  in  32  rs operand
- b  in  32  rt operand
- cancel  in  1  exception flush; aborts the in-flight operation
- id_uses_md  in  1  ID-stage instruction is MULT*/DIV*/MFHI/MFLO/MTHI/MTLO
- busy  out  1  operation in flight
- stall  out  1  stall request to hazard unit
- hi  out  32  HI register
- lo  out  32  LO register

Behaviour:
- Reset (reset=0, asynchronous):
  - state=IDLE, count=0.
  - busy=0, stall=0, hi=0, lo=0.
  - Latched operands and op are cleared.
- States: IDLE and RUN.
- IDLE, start=1, op in {0..3}:
  - Latch a, b and op.
  - Load count with MULT_CYCLES or DIV_CYCLES.
  - Go to RUN.
  - busy=1 from the next cycle.
- IDLE, start=1, op=4 (MTHI): hi<=a at that edge; stay IDLE; busy stays 0.
- IDLE, start=1, op=5 (MTLO): lo<=a at that edge; stay IDLE; busy stays 0.
- IDLE, start=1, op in {6,7}: ignored.
- RUN:
  - count decrements each cycle.
  - On the cycle where count==1, hi/lo are written at that edge; go to IDLE.
  - busy is high for exactly N cycles, where N is the op latency.
  - Start pulse at edge t: busy=1 during cycles t+1..t+N; new hi/lo visible from t+N+1, the same cycle busy drops.
- Results (computed from the latched operands):
  - MULT: {hi,lo} = signed 64-bit product.
  - MULTU: {hi,lo} = unsigned 64-bit product.
  - DIV: lo=quotient truncated toward zero; hi=remainder with the sign of the dividend.
  - Signed overflow 0x80000000 / 0xFFFFFFFF: lo=0x80000000, hi=0.
  - DIVU: unsigned quotient and remainder.
  - Divide by zero (DIV or DIVU): hi/lo unchanged; the full DIV_CYCLES latency still applies.
- start while busy (RUN): ignored for every op, including MTHI/MTLO. The pipeline cannot produce this, because stall is asserted.
- cancel:
  - In RUN: go to IDLE at the next edge; hi/lo keep their pre-operation values; busy=0 from the next cycle.
  - In IDLE: no effect.
  - Same cycle as start: cancel wins; the start is dropped, including MTHI/MTLO.
  - Same cycle as the completing edge (count==1): cancel wins; no write.
- stall (combinational) = id_uses_md & (busy | (start & op<4 & ~cancel)).
  - This covers a back-to-back HI/LO instruction issued the same cycle an operation starts.
  - stall=0 in the completion-visible cycle t+N+1, so MFHI/MFLO read the new value directly.
- hi/lo always hold the last committed value. No forwarding of in-flight results.

Decomposition:
- Shared package md_pkg holds:
  - op encoding constants MD_MULT, MD_MULTU, MD_DIV, MD_DIVU, MD_MTHI, MD_MTLO;
  - state encoding ST_IDLE, ST_RUN;
  - count width constant MD_CNT_W=4.
- One natural sub-module: md_alu, combinational. It takes latched a, b and op and outputs res_hi, res_lo and div_by_zero.
- md_ctrl keeps the FSM, counter, HI/LO registers and stall logic.

Test Plan:
- Reset low mid-RUN (3 cycles after a DIV start) -> busy=0, hi=0, lo=0 immediately, without waiting for a clock edge; after release the unit is IDLE and accepts a new start.
- MULT a=0xFFFFFFFE (-2), b=3 -> busy high exactly 5 cycles; then hi=0xFFFFFFFF, lo=0xFFFFFFFA. MULTU with the same operands -> hi=0x00000002, lo=0xFFFFFFFA.
- DIV a=0xFFFFFFF9 (-7), b=2 -> after 10 busy cycles lo=0xFFFFFFFD, hi=0xFFFFFFFF. DIV 0x80000000 / 0xFFFFFFFF -> lo=0x80000000, hi=0.
- DIVU a=5, b=0 with hi=0x11, lo=0x22 beforehand -> busy 10 cycles; hi=0x11, lo=0x22 unchanged.
- MULT start with id_uses_md=1 in the same cycle -> stall=1 that cycle and for all 5 busy cycles; stall=0 in the cycle busy falls; start pulses during busy leave hi/lo unaffected.
- MTLO a=0x1234 in IDLE -> lo=0x1234 next cycle, busy stays 0.
- DIV in flight, cancel at busy cycle 4 -> busy=0 next cycle; hi/lo keep their prior values.
- start with cancel in the same cycle -> no state change.
